// File: rtl/hilo_md_ctrl_if.sv
// HI/LO multiply/divide sequencer interface.
// master = ID stage side, slave = hilo_md_ctrl.
// Handshake: ID raises md_req with its operands. The request is taken on a
// rising edge only if md_ready is high at that edge and md_flush is low.
// A request made while md_busy is high is ignored. ID keeps itself held
// through md_stall and presents the request again. md_done pulses during the
// cycle whose closing edge commits HI/LO.
interface hilo_md_ctrl_if;
  logic        md_req;
  logic        md_mult;
  logic        md_div;
  logic        md_unsigned;
  logic [31:0] md_src1;
  logic [31:0] md_src2;
  logic        hilo_use;
  logic        mthi_we;
  logic        mtlo_we;
  logic [31:0] mt_wdata;
  logic        md_flush;
  logic        md_ready;
  logic        md_busy;
  logic        md_done;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [1:0]  dbg_state;

  modport master (
    output md_req, md_mult, md_div, md_unsigned, md_src1, md_src2,
           hilo_use, mthi_we, mtlo_we, mt_wdata, md_flush,
    input  md_ready, md_busy, md_done, md_stall, hi, lo, dbg_state
  );

  modport slave (
    input  md_req, md_mult, md_div, md_unsigned, md_src1, md_src2,
           hilo_use, mthi_we, mtlo_we, mt_wdata, md_flush,
    output md_ready, md_busy, md_done, md_stall, hi, lo, dbg_state
  );
endinterface

// File: rtl/hilo_md_ctrl.sv
// Multi-cycle multiply/divide sequencer. This block owns the HI/LO registers.
// Build option MD_FAST_MUL_EN: when defined, multiply uses a one-cycle 33x33
// signed multiplier. When undefined, multiply is a 32-step shift-add followed
// by a sign fixup. Divide is a restoring radix-2 divide in both builds.
module hilo_md_ctrl (
  input logic           clk,
  input logic           resetn,
  hilo_md_ctrl_if.slave md
);
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN_MUL = 2'd1;
  localparam logic [1:0] ST_RUN_DIV = 2'd2;
  localparam logic [1:0] ST_SIGN    = 2'd3;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [63:0] acc;     // div: {remainder, dividend/quotient}; mul: {partial, multiplier}
  logic [31:0] opb;     // divisor, or multiplicand
  logic        is_div;
  logic        neg_q;   // negate quotient (div) or the 64-bit product (mul)
  logic        neg_r;   // negate the remainder
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic        sgn;
  logic        accept;
  logic        div_zero;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [32:0] div_diff;
  logic [63:0] div_next;
  logic [31:0] sign_hi;
  logic [31:0] sign_lo;
`ifdef MD_FAST_MUL_EN
  logic        uns_q;
  logic [63:0] fast_prod;
`else
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
`endif

  assign sgn      = !md.md_unsigned;
  assign accept   = (state == ST_IDLE) && md.md_req && !md.md_flush &&
                    (md.md_mult || md.md_div);
  assign div_zero = (md.md_src2 == 32'd0);
  assign abs_a    = (sgn && md.md_src1[31]) ? -md.md_src1 : md.md_src1;
  assign abs_b    = (sgn && md.md_src2[31]) ? -md.md_src2 : md.md_src2;

  // One restoring divide step. The partial remainder stays below the divisor,
  // so bit 32 of the difference is the borrow, and that borrow is the
  // inverse of the quotient bit.
  assign div_diff = acc[63:31] - {1'b0, opb};
  assign div_next = div_diff[32] ? {acc[62:0], 1'b0}
                                 : {div_diff[31:0], acc[30:0], 1'b1};

`ifdef MD_FAST_MUL_EN
  // 33x33 signed product. Operands are sign-extended to 64 bits, and only
  // the low 64 bits of the product are kept.
  assign fast_prod = $signed({{32{!uns_q && acc[31]}}, acc[31:0]}) *
                     $signed({{32{!uns_q && opb[31]}}, opb});
`else
  // One shift-add step: add the multiplicand when the current multiplier bit
  // is set, then shift the 65-bit partial result right by one.
  assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);
  assign mul_next = {mul_sum, acc[31:1]};
`endif

  // Sign fixup for the SIGN state. A zero divisor left both flags clear, so
  // the raw quotient and the raw dividend pass through unchanged.
  always_comb begin
    sign_hi = acc[63:32];
    sign_lo = acc[31:0];
    if (is_div) begin
      if (neg_q) sign_lo = -acc[31:0];
      if (neg_r) sign_hi = -acc[63:32];
    end else if (neg_q) begin
      {sign_hi, sign_lo} = -acc;
    end
  end

  // Sequencer state, operand capture, MTHI/MTLO writes and HI/LO commit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= ST_IDLE;
      cnt    <= 5'd0;
      acc    <= 64'd0;
      opb    <= 32'd0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
`ifdef MD_FAST_MUL_EN
      uns_q  <= 1'b0;
`endif
    end else if (md.md_flush) begin
      state <= ST_IDLE;
      cnt   <= 5'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (md.mthi_we) hi_q <= md.mt_wdata;
          if (md.mtlo_we) lo_q <= md.mt_wdata;
          if (accept) begin
            cnt <= 5'd0;
            if (md.md_div) begin
              state  <= ST_RUN_DIV;
              is_div <= 1'b1;
              opb    <= abs_b;
              acc    <= {32'd0, (div_zero ? md.md_src1 : abs_a)};
              neg_q  <= sgn && !div_zero && (md.md_src1[31] ^ md.md_src2[31]);
              neg_r  <= sgn && !div_zero && md.md_src1[31];
            end else begin
              state  <= ST_RUN_MUL;
              is_div <= 1'b0;
              neg_r  <= 1'b0;
`ifdef MD_FAST_MUL_EN
              acc    <= {32'd0, md.md_src1};
              opb    <= md.md_src2;
              uns_q  <= md.md_unsigned;
              neg_q  <= 1'b0;
`else
              acc    <= {32'd0, abs_b};
              opb    <= abs_a;
              neg_q  <= sgn && (md.md_src1[31] ^ md.md_src2[31]);
`endif
            end
          end
        end
        ST_RUN_DIV: begin
          acc <= div_next;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= ST_SIGN;
        end
        ST_RUN_MUL: begin
`ifdef MD_FAST_MUL_EN
          hi_q  <= fast_prod[63:32];
          lo_q  <= fast_prod[31:0];
          state <= ST_IDLE;
`else
          acc <= mul_next;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= ST_SIGN;
`endif
        end
        default: begin
          hi_q  <= sign_hi;
          lo_q  <= sign_lo;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign md.md_busy   = (state != ST_IDLE);
  assign md.md_ready  = (state == ST_IDLE);
  assign md.md_stall  = md.md_busy && (md.md_req || md.hilo_use);
`ifdef MD_FAST_MUL_EN
  assign md.md_done   = !md.md_flush && ((state == ST_SIGN) || (state == ST_RUN_MUL));
`else
  assign md.md_done   = !md.md_flush && (state == ST_SIGN);
`endif
  assign md.hi        = hi_q;
  assign md.lo        = lo_q;
  assign md.dbg_state = state;
endmodule

// File: tb/tb_hilo_md_ctrl.sv
// Directed bench for hilo_md_ctrl. It covers reset, multiply and divide
// results and latency, divide by zero, MT writes, flush and asynchronous reset.
module tb_hilo_md_ctrl;
  logic clk;
  logic resetn;
  int   n_cmp;
  int   n_bad;
  int   stall_n;

`ifdef MD_FAST_MUL_EN
  localparam int MUL_N = 0;
`else
  localparam int MUL_N = 32;
`endif
  localparam int DIV_N = 32;

  hilo_md_ctrl_if md_if ();

  hilo_md_ctrl dut (
    .clk    (clk),
    .resetn (resetn),
    .md     (md_if)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // advance to one time unit after the next rising edge
  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    md_if.md_req      = 1'b0;
    md_if.md_mult     = 1'b0;
    md_if.md_div      = 1'b0;
    md_if.md_unsigned = 1'b0;
    md_if.md_src1     = 32'd0;
    md_if.md_src2     = 32'd0;
    md_if.hilo_use    = 1'b0;
    md_if.mthi_we     = 1'b0;
    md_if.mtlo_we     = 1'b0;
    md_if.mt_wdata    = 32'd0;
    md_if.md_flush    = 1'b0;
  endtask

  // Issue an op, measure the cycles from acceptance to md_done, then check
  // the committed HI/LO on the cycle after the commit.
  task automatic run_op(input string tag, input logic mul, input logic dv, input logic uns,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input int exp_n, input logic hold);
    int n;
    n = 0;
    stall_n = 0;
    md_if.md_req      = 1'b1;
    md_if.md_mult     = mul;
    md_if.md_div      = dv;
    md_if.md_unsigned = uns;
    md_if.md_src1     = a;
    md_if.md_src2     = b;
    go();
    md_if.md_req = hold;
    #1;
    while (!md_if.md_done && n < 40) begin
      if (md_if.md_stall) stall_n++;
      go();
      n++;
    end
    if (md_if.md_stall) stall_n++;
    chk({tag, " latency"}, 32'(n), 32'(exp_n));
    go();
    md_if.md_req = 1'b0;
    #1;
    chk({tag, " hi"}, md_if.hi, exp_hi);
    chk({tag, " lo"}, md_if.lo, exp_lo);
    chk({tag, " busy after commit"}, {31'd0, md_if.md_busy}, 32'd0);
  endtask

  initial begin
    int done_seen;
    n_cmp = 0;
    n_bad = 0;
    stall_n = 0;
    idle_inputs();
    resetn = 1'b0;

    // reset state
    #12;
    chk("reset hi", md_if.hi, 32'd0);
    chk("reset lo", md_if.lo, 32'd0);
    chk("reset ready", {31'd0, md_if.md_ready}, 32'd1);
    chk("reset busy", {31'd0, md_if.md_busy}, 32'd0);
    chk("reset done", {31'd0, md_if.md_done}, 32'd0);
    chk("reset state", {30'd0, md_if.dbg_state}, 32'd0);
    resetn = 1'b1;
    go();

    // MULT -3 x 5
    run_op("mult -3x5", 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFD, 32'd5,
           32'hFFFF_FFFF, 32'hFFFF_FFF1, MUL_N, 1'b0);

    // DIVU 100/7 with an MFHI waiting in ID and md_req held throughout
    md_if.hilo_use = 1'b1;
    run_op("divu 100/7", 1'b0, 1'b1, 1'b1, 32'd100, 32'd7,
           32'd2, 32'd14, DIV_N, 1'b1);
    chk("divu stall cycles", 32'(stall_n), 32'd33);
    chk("stall after commit", {31'd0, md_if.md_stall}, 32'd0);
    md_if.hilo_use = 1'b0;

    // signed divide sign rules
    run_op("div -7/2", 1'b0, 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_N, 1'b0);
    run_op("div 7/-2", 1'b0, 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFE,
           32'd1, 32'hFFFF_FFFD, DIV_N, 1'b0);
    run_op("div min/-1", 1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF,
           32'd0, 32'h8000_0000, DIV_N, 1'b0);
    run_op("divu max/16", 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd16,
           32'd15, 32'h0FFF_FFFF, DIV_N, 1'b0);
    run_op("mult min*min", 1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000,
           32'h4000_0000, 32'd0, MUL_N, 1'b0);

    // divide by zero, then MTLO in IDLE
    run_op("div 9/0", 1'b0, 1'b1, 1'b0, 32'd9, 32'd0,
           32'd9, 32'hFFFF_FFFF, DIV_N, 1'b0);
    md_if.mtlo_we  = 1'b1;
    md_if.mt_wdata = 32'h0000_1234;
    go();
    md_if.mtlo_we = 1'b0;
    chk("mtlo lo", md_if.lo, 32'h0000_1234);
    chk("mtlo hi kept", md_if.hi, 32'd9);

    // MTHI during a flush is ignored
    md_if.mthi_we  = 1'b1;
    md_if.md_flush = 1'b1;
    md_if.mt_wdata = 32'hDEAD_BEEF;
    go();
    md_if.mthi_we  = 1'b0;
    md_if.md_flush = 1'b0;
    chk("mthi under flush", md_if.hi, 32'd9);

    // DIVU flushed at cycle 10; a request in the flush cycle is dropped
    done_seen = 0;
    md_if.md_req      = 1'b1;
    md_if.md_mult     = 1'b0;
    md_if.md_div      = 1'b1;
    md_if.md_unsigned = 1'b1;
    md_if.md_src1     = 32'd1000;
    md_if.md_src2     = 32'd3;
    go();
    md_if.md_req = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (md_if.md_done) done_seen++;
      go();
    end
    chk("busy before flush", {31'd0, md_if.md_busy}, 32'd1);
    md_if.md_flush = 1'b1;
    md_if.md_req   = 1'b1;
    #1;
    if (md_if.md_done) done_seen++;
    go();
    md_if.md_flush = 1'b0;
    md_if.md_req   = 1'b0;
    chk("flush idle ready", {31'd0, md_if.md_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      if (md_if.md_done) done_seen++;
      go();
    end
    chk("flush no done", 32'(done_seen), 32'd0);
    chk("flush req dropped", {31'd0, md_if.md_busy}, 32'd0);
    chk("flush hi kept", md_if.hi, 32'd9);
    chk("flush lo kept", md_if.lo, 32'h0000_1234);

    // asynchronous reset in the middle of a divide
    md_if.md_req      = 1'b1;
    md_if.md_div      = 1'b1;
    md_if.md_unsigned = 1'b0;
    md_if.md_src1     = 32'd50;
    md_if.md_src2     = 32'd5;
    go();
    md_if.md_req = 1'b0;
    for (int i = 0; i < 4; i++) go();
    #2;
    resetn = 1'b0;
    #1;
    chk("async rst hi", md_if.hi, 32'd0);
    chk("async rst lo", md_if.lo, 32'd0);
    chk("async rst ready", {31'd0, md_if.md_ready}, 32'd1);
    chk("async rst busy", {31'd0, md_if.md_busy}, 32'd0);
    #2;
    resetn = 1'b1;
    go();
    run_op("multu max*2", 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2,
           32'd1, 32'hFFFF_FFFE, MUL_N, 1'b0);
    // the next op goes in on the cycle straight after the commit
    run_op("divu b2b 7/7", 1'b0, 1'b1, 1'b1, 32'd7, 32'd7,
           32'd0, 32'd1, DIV_N, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
